// File: rtl/ours_axi4_r_rr_arb_v2.sv
// Burst-aware round-robin arbiter merging N_INPUT AXI4 R channels onto one master port.
// Optional per-input completed-burst counters are built when OURS_R_ARB_PERF_EN is defined.
module ours_axi4_r_rr_arb_v2 #(
   parameter int N_INPUT        = 4,
   parameter int WIDTH          = 64,
   parameter int RLAST_POSITION = 0,
   parameter int LOCK_BURST     = 1,
   parameter int OUT_REG        = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_INPUT-1:0]                   slave_rvld,
   input  logic [N_INPUT-1:0][WIDTH-1:0]        slave_r,
   output logic [N_INPUT-1:0]                   slave_rrdy,
   output logic                                 master_rvld,
   output logic [WIDTH-1:0]                     master_r,
   input  logic                                 master_rrdy,
   output logic                                 clk_en,
   output logic [N_INPUT-1:0][CNT_WIDTH-1:0]    burst_cnt
);

   localparam int IDX_W = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;

   logic             lock;
   logic [IDX_W-1:0] lock_idx;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] win_idx;
   logic             win_vld;
   logic [WIDTH-1:0] win_r;
   logic             win_last;
   logic             acc;
   logic             xfer;
   logic             fifo_full;
   logic             fifo_empty;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin : winner_sel
      int               cand;
      logic [IDX_W-1:0] cidx;
      cand    = 0;
      cidx    = '0;
      win_idx = '0;
      win_vld = 1'b0;
      if (lock) begin
         win_idx = lock_idx;
         win_vld = slave_rvld[lock_idx];
      end else begin
         // Scan from the far end back towards ptr so the nearest requester is written last.
         for (int k = N_INPUT - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N_INPUT) cand = cand - N_INPUT;
            cidx = IDX_W'(cand);
            if (slave_rvld[cidx]) begin
               win_idx = cidx;
               win_vld = 1'b1;
            end
         end
      end
   end

   assign win_r    = slave_r[win_idx];
   assign win_last = win_r[RLAST_POSITION];
   assign acc      = (OUT_REG != 0) ? ~fifo_full : master_rrdy;
   assign xfer     = win_vld & acc & ~rst;
   assign clk_en   = rst | (|slave_rvld) | lock | ~fifo_empty;

   always_comb begin
      slave_rrdy = '0;
      if (win_vld && !rst) slave_rrdy[win_idx] = acc;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock     <= 1'b0;
         lock_idx <= '0;
         ptr      <= '0;
      end else if (xfer && N_INPUT > 1) begin
         if (LOCK_BURST != 0 && !win_last) begin
            lock     <= 1'b1;
            lock_idx <= win_idx;
         end else begin
            lock <= 1'b0;
            ptr  <= (win_idx == IDX_W'(N_INPUT - 1)) ? '0 : win_idx + IDX_W'(1);
         end
      end
   end

   if (OUT_REG != 0) begin : g_fifo
      logic [WIDTH-1:0] mem [2];
      logic             wr_ptr;
      logic             rd_ptr;
      logic [1:0]       count;
      logic             pop;

      assign pop = (count != 2'd0) & master_rrdy;

      // NOTE: payload storage has no reset; an entry is only visible once count says it was written.
      always_ff @(posedge clk) begin
         if (xfer) mem[wr_ptr] <= win_r;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (xfer) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(xfer) - 2'(pop);
         end
      end

      assign fifo_full   = (count == 2'd2);
      assign fifo_empty  = (count == 2'd0);
      assign master_rvld = ~fifo_empty;
      assign master_r    = mem[rd_ptr];
   end else begin : g_pass
      assign fifo_full   = 1'b0;
      assign fifo_empty  = 1'b1;
      assign master_rvld = win_vld & ~rst;
      assign master_r    = win_r;
   end

`ifdef OURS_R_ARB_PERF_EN
   logic [N_INPUT-1:0][CNT_WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (xfer && win_last && cnt[win_idx] != '1) begin
         cnt[win_idx] <= cnt[win_idx] + CNT_WIDTH'(1);
      end
   end

   assign burst_cnt = cnt;
`else
   assign burst_cnt = '0;
`endif

endmodule

// File: doc/ours_axi4_r_rr_arb_v2.md
Name: ours_axi4_r_rr_arb_v2

Overview:
Single-level, burst-aware round-robin arbiter for AXI4 R channels, with a parametrised number of inputs (1..32). It replaces the two-layer tree of fixed 4-port arbiters in the read-return path of the memory interconnect. The block supports burst-locked or beat-interleaved grant, an optional 2-entry registered output stage, and a clock-gating request output.

Parameters:
N_INPUT, 4, number of slave R inputs; legal range 1..32.
WIDTH, 64, packed R payload width in bits.
RLAST_POSITION, 0, bit index of rlast inside the payload.
LOCK_BURST, 1, 1 = hold grant until the rlast beat transfers; 0 = re-arbitrate every beat.
OUT_REG, 1, 1 = 2-entry output FIFO between arbiter and master; 0 = combinational pass-through.
CNT_WIDTH, 16, width of each performance counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
slave_rvld  input  N_INPUT  per-input beat valid
slave_r  input  N_INPUT*WIDTH  per-input payload, packed [N_INPUT-1:0][WIDTH-1:0]
slave_rrdy  output  N_INPUT  per-input ready; at most one bit high
master_rvld  output  1  merged beat valid
master_r  output  WIDTH  merged payload
master_rrdy  input  1  downstream ready
clk_en  output  1  request for the upstream ICG
burst_cnt  output  N_INPUT*CNT_WIDTH  per-input completed-burst counters (see Optional Feature)

Behaviour:
- Reset: all state registers clear asynchronously. State is lock=0, lock_idx=0, ptr=0, FIFO empty, counters=0. master_rvld=0. While rst=1: slave_rrdy=0 and clk_en=1.
- acc = OUT_REG ? ~fifo_full : master_rrdy.
- Winner selection (combinational): if lock=1, winner=lock_idx, considered only while slave_rvld[lock_idx]=1. Otherwise the winner is the first i with slave_rvld[i]=1, scanning from ptr upward and wrapping modulo N_INPUT.
- slave_rrdy[winner]=acc; all other bits are 0. A transfer happens when slave_rvld[w] & slave_rrdy[w].
- Transfer without rlast, when LOCK_BURST=1: set lock=1 and lock_idx=w.
- Transfer with rlast, or any transfer when LOCK_BURST=0: clear lock and set ptr=(w+1) mod N_INPUT. Wrap at N_INPUT-1 goes to 0.
- While locked, a valid on another input is never granted, even if the locked input is idle.
- OUT_REG=0: master_rvld/master_r equal the winner's valid/payload, so latency is 0 cycles.
- OUT_REG=1: 2-entry FIFO with push=transfer and pop=master_rvld&master_rrdy. master_r is the head entry.
  - Latency is 1 cycle. Full throughput of 1 beat/cycle with master_rrdy held high.
  - Simultaneous push and pop when full: push is blocked, because acc is computed from the current fifo_full.
  - Simultaneous push and pop at count 1: count stays 1.
- N_INPUT=1: no arbitration; ptr and lock are held constant and the input path passes straight through (or through the FIFO).
- clk_en = rst | (|slave_rvld) | lock | ~fifo_empty. When OUT_REG=0, fifo_empty is taken as 1.
- Reset asserted mid-burst: lock and FIFO contents are discarded. After release, arbitration restarts from ptr=0.
- Payload is never modified; rlast is read only from bit RLAST_POSITION.

Optional Feature:
Macro OURS_R_ARB_PERF_EN.
- Defined: burst_cnt[i] increments by 1 on each rlast transfer from input i. It saturates at 2^CNT_WIDTH-1 and clears only on rst.
- Not defined: no counter registers are built and burst_cnt is tied to 0.
- Arbitration behaviour is identical in both builds.

Test Plan:
- Reset check: N_INPUT=4, OUT_REG=1, rst=1 with all slave_rvld=1 -> slave_rrdy=0, master_rvld=0, clk_en=1. Deassert -> input 0 granted in the first cycle, master_rvld=1 one cycle later.
- Burst lock: inputs 0 and 2 each send a 4-beat burst, master_rrdy=1, LOCK_BURST=1 -> output is 4 beats of input 0 then 4 beats of input 2, never interleaved; ptr=3 afterwards.
- Beat interleave: LOCK_BURST=0, inputs 1 and 3 continuously valid -> output alternates 1,3,1,3 at one beat per cycle.
- Backpressure: OUT_REG=1, master_rrdy=0 for 5 cycles -> exactly 2 beats accepted, then all slave_rrdy=0. Release -> no beat lost or duplicated, order preserved.
- Wrap-around: N_INPUT=5, ptr=4, valids on inputs 4 and 0 -> 4 is granted first, then 0; ptr ends at 1.
- Perf counters (with OURS_R_ARB_PERF_EN, CNT_WIDTH=2): 5 single-beat bursts on input 1 -> burst_cnt[1]=3 (saturated), all other counters 0. Without the macro, all counters read 0.
